// File: rtl/GPU_Shader_pkg.sv
// Shared shader-core types: data word, storage depth and write-buffer entry.
package GPU_Shader_pkg;

    localparam int WORD_W    = 32;
    localparam int MEM_DEPTH = 16;
    localparam int ADDR_W    = $clog2(MEM_DEPTH);

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // One buffered store: target address plus data word.
    typedef struct packed {
        addr_t addr;
        word_t data;
    } wbuf_entry_t;

endpackage

// File: rtl/dmem_wbuf.sv
// In-order store write buffer (FIFO) with a newest-match address search
// over the currently buffered entries. Pointers wrap modulo DEPTH.
module dmem_wbuf
    import GPU_Shader_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  wbuf_entry_t push_entry,
    input  logic        pop,
    input  addr_t       lookup_addr,
    output wbuf_entry_t head_entry,
    output logic        full,
    output logic        empty,
    output logic        match_any,
    output word_t       match_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    wbuf_entry_t      entries_r [DEPTH];

    logic             push_ok_s;
    logic             pop_ok_s;
    logic [PTR_W-1:0] idx_s;
    logic             hit_s;

    assign full       = (count_r == CNT_W'(DEPTH));
    assign empty      = (count_r == {CNT_W{1'b0}});
    assign push_ok_s  = push & ~full;
    assign pop_ok_s   = pop & ~empty;
    assign head_entry = entries_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; validity is tracked by the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            entries_r[wr_ptr_r] <= push_entry;
        end
    end

    // Scan oldest to newest so the newest matching entry wins.
    always_comb begin
        match_any  = 1'b0;
        match_data = {WORD_W{1'b0}};
        idx_s      = {PTR_W{1'b0}};
        hit_s      = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s      = rd_ptr_r + PTR_W'(i);
            hit_s      = (CNT_W'(i) < count_r) && (entries_r[idx_s].addr == lookup_addr);
            match_any  = match_any | hit_s;
            match_data = hit_s ? entries_r[idx_s].data : match_data;
        end
    end

endmodule

// File: rtl/shader_dmem_resp.sv
// Shader data-memory response path: single-port word storage fronted by an
// in-order write buffer. Loads take priority over draining unless the buffer
// is full. Build option DMEM_FWD_EN: forward load data from the newest
// matching buffered store; without it, a matching load stalls until drained.
module shader_dmem_resp
    import GPU_Shader_pkg::*;
#(
    parameter int MEM_DEPTH  = GPU_Shader_pkg::MEM_DEPTH,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         mem_write_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_write_addr,
    input  word_t                        mem_write_data,
    output logic                         wr_full,
    input  logic                         rd_req,
    input  logic [$clog2(MEM_DEPTH)-1:0] rd_addr,
    output logic                         rd_ready,
    output logic                         rd_valid,
    output word_t                        mem_read_data,
    output logic                         wr_overflow
);

    localparam int AW = $clog2(MEM_DEPTH);

`ifdef DMEM_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    word_t       mem_r [MEM_DEPTH];
    logic        init_done_r;
    logic        rd_valid_r;
    word_t       rd_data_r;
    logic        overflow_r;

    logic        full_s;
    logic        empty_s;
    logic        match_any_s;
    word_t       match_data_s;
    wbuf_entry_t head_s;
    wbuf_entry_t push_entry_s;
    logic        push_s;
    logic        drain_s;
    logic        rd_ready_s;
    logic        rd_acc_s;
    word_t       rd_word_s;

    assign push_entry_s.addr = addr_t'(mem_write_addr);
    assign push_entry_s.data = mem_write_data;

    // Stores are ignored during the first cycle out of reset.
    assign push_s   = mem_write_en & ~full_s & init_done_r;
    assign rd_acc_s = rd_req & rd_ready_s;
    assign drain_s  = ~empty_s & ~rd_acc_s;

    dmem_wbuf #(
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push_s),
        .push_entry  (push_entry_s),
        .pop         (drain_s),
        .lookup_addr (addr_t'(rd_addr)),
        .head_entry  (head_s),
        .full        (full_s),
        .empty       (empty_s),
        .match_any   (match_any_s),
        .match_data  (match_data_s)
    );

    // Load acceptance: blocked out of reset, when full (drain wins), and on a
    // buffered address hazard unless forwarding resolves it.
    always_comb begin
        rd_ready_s = 1'b0;
        if (!init_done_r) begin
            rd_ready_s = 1'b0;
        end else if (full_s) begin
            rd_ready_s = 1'b0;
        end else begin
            rd_ready_s = FWD_EN | ~match_any_s;
        end
    end

    // Load data source: newest buffered match when forwarding, else storage.
    always_comb begin
        rd_word_s = mem_r[rd_addr];
        if (FWD_EN && match_any_s) begin
            rd_word_s = match_data_s;
        end else begin
            rd_word_s = mem_r[rd_addr];
        end
    end

    // First-cycle-after-reset qualifier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done_r <= 1'b0;
        end else begin
            init_done_r <= 1'b1;
        end
    end

    // Single-port storage write; only the drain writes, never alongside a load.
    always_ff @(posedge clk) begin
        if (drain_s) begin
            mem_r[AW'(head_s.addr)] <= head_s.data;
        end
    end

    // Registered load response; data holds between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= {WORD_W{1'b0}};
        end else begin
            rd_valid_r <= rd_acc_s;
            if (rd_acc_s) begin
                rd_data_r <= rd_word_s;
            end
        end
    end

    // Sticky flag for stores dropped against a full buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
        end else if (mem_write_en && full_s) begin
            overflow_r <= 1'b1;
        end
    end

    assign wr_full       = full_s;
    assign rd_ready      = rd_ready_s;
    assign rd_valid      = rd_valid_r;
    assign mem_read_data = rd_data_r;
    assign wr_overflow   = overflow_r;

endmodule

// File: tb/tb_shader_dmem_resp.sv
// Directed bench for shader_dmem_resp. Inputs change on the falling edge;
// outputs are sampled 1 ns later. Builds with or without DMEM_FWD_EN.
`timescale 1ns/1ps
module tb_shader_dmem_resp;
    import GPU_Shader_pkg::*;

    localparam int AW = $clog2(MEM_DEPTH);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_write_en;
    logic [AW-1:0] mem_write_addr;
    word_t         mem_write_data;
    logic          wr_full;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ready;
    logic          rd_valid;
    word_t         mem_read_data;
    logic          wr_overflow;

    int n_checks = 0;
    int n_pass   = 0;

    shader_dmem_resp dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_write_en   (mem_write_en),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .wr_full        (wr_full),
        .rd_req         (rd_req),
        .rd_addr        (rd_addr),
        .rd_ready       (rd_ready),
        .rd_valid       (rd_valid),
        .mem_read_data  (mem_read_data),
        .wr_overflow    (wr_overflow)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_store(input logic en, input logic [AW-1:0] a, input logic [31:0] d);
        mem_write_en   = en;
        mem_write_addr = a;
        mem_write_data = d;
    endtask

    // Issue a load, wait a bounded number of cycles for acceptance, check response.
    task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
        int waited;
        waited  = 0;
        rd_req  = 1'b1;
        rd_addr = a;
        #1;
        while (!rd_ready && waited < 10) begin
            step();
            #1;
            waited++;
        end
        check_val({tag, "_ready"}, 32'(rd_ready), 32'd1);
        step();
        rd_req = 1'b0;
        #1;
        check_val({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check_val({tag, "_data"}, mem_read_data, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        set_store(1'b0, 4'd0, 32'd0);
        rd_req  = 1'b0;
        rd_addr = 4'd0;
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_full",     32'(wr_full),     32'd0);
        check_val("rst_ready",    32'(rd_ready),    32'd0);
        check_val("rst_valid",    32'(rd_valid),    32'd0);
        check_val("rst_data",     mem_read_data,    32'd0);
        check_val("rst_overflow", 32'(wr_overflow), 32'd0);

        // Release reset; first cycle ignores both a store and a load to @5.
        rst_n = 1'b1;
        set_store(1'b1, 4'd5, 32'h1234_5678);
        rd_req  = 1'b1;
        rd_addr = 4'd5;
        #1;
        check_val("init_rd_ready", 32'(rd_ready), 32'd0);
        step();
        set_store(1'b0, 4'd0, 32'd0);
        rd_req = 1'b0;
        #1;
        check_val("init_rd_ignored", 32'(rd_valid), 32'd0);
        check_val("init_st_ignored", 32'(rd_ready), 32'd1);

        // Preload known storage contents used by later checks.
        set_store(1'b1, 4'd8,  32'h0000_0000); step();
        set_store(1'b1, 4'd10, 32'h0000_1010); step();
        set_store(1'b1, 4'd11, 32'h0000_1111); step();
        set_store(1'b1, 4'd12, 32'h0000_1212); step();
        set_store(1'b1, 4'd6,  32'h0000_0606); step();
        set_store(1'b0, 4'd0, 32'd0);
        repeat (3) step();

        // Store, idle two cycles, load back.
        set_store(1'b1, 4'd5, 32'hDEAD_BEEF); step();
        set_store(1'b0, 4'd0, 32'd0);
        repeat (2) step();
        do_read("basic", 4'd5, 32'hDEAD_BEEF);
        step();
        #1;
        check_val("basic_pulse", 32'(rd_valid), 32'd0);
        check_val("basic_hold",  mem_read_data, 32'hDEAD_BEEF);

        // Fill the buffer while loads to @9 block draining; fifth store drops.
        rd_req  = 1'b1;
        rd_addr = 4'd9;
        for (int i = 1; i <= 4; i++) begin
            set_store(1'b1, 4'(i), 32'h100 + 32'(i));
            step();
        end
        #1;
        check_val("fill_full",  32'(wr_full),  32'd1);
        check_val("fill_ready", 32'(rd_ready), 32'd0);
        set_store(1'b1, 4'd6, 32'h0000_0105);
        step();
        set_store(1'b0, 4'd0, 32'd0);
        #1;
        check_val("fill_overflow", 32'(wr_overflow), 32'd1);
        check_val("fill_stall",    32'(rd_valid),    32'd0);
        check_val("fill_unfull",   32'(wr_full),     32'd0);
        check_val("fill_ready2",   32'(rd_ready),    32'd1);
        rd_req = 1'b0;
        repeat (4) step();
        do_read("fill_drained", 4'd4, 32'h0000_0104);
        do_read("fill_dropped", 4'd6, 32'h0000_0606);
        check_val("overflow_sticky", 32'(wr_overflow), 32'd1);

        // Load hitting a just-buffered store.
        set_store(1'b1, 4'd7, 32'h0000_0011); step();
        set_store(1'b0, 4'd0, 32'd0);
        rd_req  = 1'b1;
        rd_addr = 4'd7;
        #1;
`ifdef DMEM_FWD_EN
        check_val("hazard_fwd_ready", 32'(rd_ready), 32'd1);
        step();
`else
        check_val("hazard_stall", 32'(rd_ready), 32'd0);
        step();
        #1;
        check_val("hazard_drained", 32'(rd_ready), 32'd1);
        step();
`endif
        rd_req = 1'b0;
        #1;
        check_val("hazard_valid", 32'(rd_valid),  32'd1);
        check_val("hazard_data",  mem_read_data,  32'h0000_0011);
        repeat (3) step();

        // Two stores to @3 held in the buffer; load must see the newer one.
        rd_req  = 1'b1;
        rd_addr = 4'd9;
        set_store(1'b1, 4'd3, 32'h0000_000A); step();
        set_store(1'b1, 4'd3, 32'h0000_000B); step();
        set_store(1'b0, 4'd0, 32'd0);
        rd_req = 1'b0;
        do_read("newest", 4'd3, 32'h0000_000B);
        repeat (3) step();

        // Same-cycle store and load to @8: load sees the old value.
        set_store(1'b1, 4'd8, 32'h0000_0022);
        rd_req  = 1'b1;
        rd_addr = 4'd8;
        #1;
        check_val("same_ready", 32'(rd_ready), 32'd1);
        step();
        set_store(1'b0, 4'd0, 32'd0);
        rd_req = 1'b0;
        #1;
        check_val("same_valid", 32'(rd_valid), 32'd1);
        check_val("same_old",   mem_read_data, 32'h0000_0000);
        do_read("same_new", 4'd8, 32'h0000_0022);
        repeat (3) step();

        // Three buffered stores discarded by a mid-operation reset.
        rd_req  = 1'b1;
        rd_addr = 4'd9;
        set_store(1'b1, 4'd10, 32'hAAAA_0010); step();
        set_store(1'b1, 4'd11, 32'hAAAA_0011); step();
        set_store(1'b1, 4'd12, 32'hAAAA_0012); step();
        set_store(1'b0, 4'd0, 32'd0);
        rd_req = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_val("mrst_full",     32'(wr_full),     32'd0);
        check_val("mrst_overflow", 32'(wr_overflow), 32'd0);
        check_val("mrst_valid",    32'(rd_valid),    32'd0);
        check_val("mrst_ready",    32'(rd_ready),    32'd0);
        check_val("mrst_data",     mem_read_data,    32'd0);
        step();
        rst_n = 1'b1;
        step();
        do_read("mrst_a10", 4'd10, 32'h0000_1010);
        do_read("mrst_a11", 4'd11, 32'h0000_1111);
        do_read("mrst_a12", 4'd12, 32'h0000_1212);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/shader_dmem_resp.md
SHADER_DMEM_RESP -- requirements
Module: shader_dmem_resp

Interface
REQ-001 SHALL take parameter MEM_DEPTH, default GPU_Shader_pkg::MEM_DEPTH, number of word_t storage entries.
REQ-002 SHALL take parameter WBUF_DEPTH, default 4, write-buffer entries (power of 2, >=2).
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port mem_write_en, input, 1, store request from ALU.
REQ-006 SHALL have port mem_write_addr, input, $clog2(MEM_DEPTH), store address.
REQ-007 SHALL have port mem_write_data, input, word_t, store data.
REQ-008 SHALL have port wr_full, output, 1, write buffer full (upstream stall).
REQ-009 SHALL have port rd_req, input, 1, load request.
REQ-010 SHALL have port rd_addr, input, $clog2(MEM_DEPTH), load address.
REQ-011 SHALL have port rd_ready, output, 1, load accepted this cycle when rd_req & rd_ready.
REQ-012 SHALL have port rd_valid, output, 1, one-cycle pulse marking mem_read_data valid.
REQ-013 SHALL have port mem_read_data, output, word_t, load data to ALU, registered.
REQ-014 SHALL have port wr_overflow, output, 1, sticky: store was dropped.

Function
REQ-015 SHALL enqueue a store into an in-order write-buffer FIFO when mem_write_en=1 and wr_full=0.
REQ-016 SHALL drop a store arriving with wr_full=1 and set wr_overflow, which holds until reset.
REQ-017 SHALL assert wr_full combinationally when count==WBUF_DEPTH.
REQ-018 SHALL permit enqueue and drain in the same cycle; count is unchanged in that cycle.
REQ-019 SHALL use single-port storage: each cycle performs one accepted read or one drain, never both.
REQ-020 SHALL give priority to an accepted read over draining, except when count==WBUF_DEPTH, where drain wins and rd_ready=0.
REQ-021 SHALL drain the oldest entry into storage whenever the buffer is non-empty and no read is accepted.
REQ-022 SHALL return an accepted read with rd_valid=1 and mem_read_data exactly one cycle after acceptance.
REQ-023 SHALL make a store enqueued in the same cycle as an accepted read to the same address invisible to that read.
REQ-024 SHALL keep mem_read_data at its last value when rd_valid=0.
REQ-025 SHALL wrap FIFO pointers modulo WBUF_DEPTH.

Reset
REQ-026 SHALL, while rst_n=0, force count, pointers, rd_valid, wr_overflow and mem_read_data to 0, wr_full=0 and rd_ready=0.
REQ-027 SHALL discard buffered (undrained) stores on reset mid-operation; storage contents are not reset.
REQ-028 SHALL ignore stores and reads in the first cycle after rst_n deasserts.

Configuration
REQ-029 SHALL, with DMEM_FWD_EN defined, forward data for an accepted read from the newest buffered entry whose address matches rd_addr, else from storage.
REQ-030 SHALL, without DMEM_FWD_EN, hold rd_ready=0 while any buffered entry matches rd_addr, so drain resolves the hazard before the read is accepted.

Structure
REQ-031 SHALL take word_t and MEM_DEPTH from GPU_Shader_pkg and add wbuf_entry_t (addr, data) there.
REQ-032 SHALL implement the write buffer as sub-module dmem_wbuf (FIFO plus address-match search).

Verification
REQ-033 SHALL cover: store 0xDEADBEEF @5, idle 2 cycles, read @5 -> rd_valid 1 cycle later, data 0xDEADBEEF.
REQ-034 SHALL cover: 4 stores @1..4 with rd_req held to @9 -> wr_full=1 after 4th; 5th store sets wr_overflow; rd_ready=0 until one drain.
REQ-035 SHALL cover: store 0x11 @7, next cycle read @7 -> with DMEM_FWD_EN data 0x11 one cycle after acceptance; without it, rd_ready=0 until drain, then 0x11.
REQ-036 SHALL cover: stores 0xA then 0xB to @3 with no drain, read @3 under DMEM_FWD_EN -> 0xB.
REQ-037 SHALL cover: same-cycle store 0x22 @8 and read @8 (old 0x00) -> read returns 0x00; later read returns 0x22.
REQ-038 SHALL cover: 3 buffered stores, rst_n pulsed low -> count 0, wr_full 0, wr_overflow 0, rd_valid 0; stores never reach storage.
